// File: rtl/up_down_count_monitor.sv
// Receiving-end checker for an up/down count bus: infers direction, tracks lock,
// and flags wraps, reversals and illegal steps with saturating statistics.
//
// state | meaning
// IDLE  | no history; next valid sample only seeds prev
// ACQ   | have a reference sample, waiting for a legal +1/-1 step to lock
// LOCK  | direction known, every valid sample is checked against prev
module up_down_count_monitor #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             dir,
    output logic             wrap,
    output logic             rev,
    output logic             step_err,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_W   = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               locked_q, locked_d;
    logic               dir_q, dir_d;
    logic               wrap_q, wrap_d;
    logic               rev_q, rev_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;

    logic [WIDTH-1:0]   prev_inc, prev_dec;
    logic               is_hold, is_inc, is_dec;
    logic               step_up, step_dn, crosses;

    always_comb begin
        prev_inc = prev_q + ONE_W;
        prev_dec = prev_q - ONE_W;
        is_hold  = (count == prev_q);
        is_inc   = (count == prev_inc);
        is_dec   = (count == prev_dec);
        // Only a 1-bit bus makes +1 and -1 identical; keep the current direction then.
        if (is_inc && is_dec) begin
            step_dn = locked_q && dir_q;
            step_up = !step_dn;
        end else begin
            step_up = is_inc;
            step_dn = is_dec;
        end
        crosses = step_up ? (prev_q == MAX_W) : (prev_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        locked_d = locked_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        rev_d    = 1'b0;
        err_d    = 1'b0;
        wcnt_d   = wcnt_q;
        ecnt_d   = ecnt_q;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    prev_d  = count;
                    state_d = ACQ;
                end
                ACQ, LOCK: begin
                    prev_d = count;
                    if (is_hold) begin
                        state_d = state_q;
                    end else if (step_up || step_dn) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                        dir_d    = step_dn;
                        rev_d    = (state_q == LOCK) && (step_dn != dir_q);
                        wrap_d   = crosses;
                        if (crosses && (wcnt_q != CNT_MAX)) begin
                            wcnt_d = wcnt_q + ONE_C;
                        end
                    end else begin
                        state_d  = ACQ;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        if (ecnt_q != CNT_MAX) begin
                            ecnt_d = ecnt_q + ONE_C;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            locked_q <= 1'b0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            rev_q    <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            locked_q <= locked_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            rev_q    <= rev_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign locked     = locked_q;
    assign dir        = dir_q;
    assign wrap       = wrap_q;
    assign rev        = rev_q;
    assign step_err   = err_q;
    assign wrap_count = wcnt_q;
    assign err_count  = ecnt_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor: two instances (wide and 2-bit statistics)
// checked every cycle against an arithmetic model, plus hand-computed spot checks.
module tb_up_down_count_monitor;

    localparam int W = 3;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] count = '0;

    logic       locked_a, dir_a, wrap_a, rev_a, err_a;
    logic [7:0] wc_a, ec_a;
    logic       locked_b, dir_b, wrap_b, rev_b, err_b;
    logic [1:0] wc_b, ec_b;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    up_down_count_monitor #(.WIDTH(W), .CNT_W(8)) dut_a (
        .clk(clk), .clr(clr), .in_valid(in_valid), .count(count),
        .locked(locked_a), .dir(dir_a), .wrap(wrap_a), .rev(rev_a),
        .step_err(err_a), .wrap_count(wc_a), .err_count(ec_a)
    );

    up_down_count_monitor #(.WIDTH(W), .CNT_W(2)) dut_b (
        .clk(clk), .clr(clr), .in_valid(in_valid), .count(count),
        .locked(locked_b), .dir(dir_b), .wrap(wrap_b), .rev(rev_b),
        .step_err(err_b), .wrap_count(wc_b), .err_count(ec_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sequence history as plain integers, step = difference mod M.
    bit m_have, m_locked, m_dir, m_wrap, m_rev, m_err;
    int m_prev, m_wc, m_ec;

    always @(posedge clk or negedge clr) begin : model
        int c, d;
        bit down;
        if (!clr) begin
            m_have = 0; m_locked = 0; m_dir = 0;
            m_wrap = 0; m_rev = 0; m_err = 0;
            m_prev = 0; m_wc = 0; m_ec = 0;
        end else begin
            m_wrap = 0; m_rev = 0; m_err = 0;
            if (in_valid) begin
                c = int'(count);
                if (!m_have) begin
                    m_have = 1;
                end else begin
                    d = (c - m_prev + M) % M;
                    if (d == 1 || d == M - 1) begin
                        down = (d == M - 1);
                        m_rev = m_locked && (down != m_dir);
                        m_dir = down;
                        m_locked = 1;
                        m_wrap = down ? (c == M - 1) : (c == 0);
                        if (m_wrap) m_wc++;
                    end else if (d != 0) begin
                        m_err = 1;
                        m_ec++;
                        m_locked = 0;
                    end
                end
                m_prev = c;
            end
        end
    end

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("locked_a", locked_a, m_locked);
            chk("dir_a", dir_a, m_dir);
            chk("wrap_a", wrap_a, m_wrap);
            chk("rev_a", rev_a, m_rev);
            chk("step_err_a", err_a, m_err);
            chk("wrap_count_a", wc_a, sat(m_wc, 255));
            chk("err_count_a", ec_a, sat(m_ec, 255));
            chk("locked_b", locked_b, m_locked);
            chk("dir_b", dir_b, m_dir);
            chk("wrap_b", wrap_b, m_wrap);
            chk("rev_b", rev_b, m_rev);
            chk("step_err_b", err_b, m_err);
            chk("wrap_count_b", wc_b, sat(m_wc, 3));
            chk("err_count_b", ec_b, sat(m_ec, 3));
        end
    end

    task automatic smp(input bit v, input int c);
        in_valid = v;
        count = W'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #1 clr = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_locked", locked_a, 0);
        chk("rst_wrap_count", wc_a, 0);
        chk("rst_err_count", ec_a, 0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        check_en = 1'b1;

        // up run 5,6,7,0,1
        smp(1, 5); chk("up_not_locked_after_first", locked_a, 0);
        smp(1, 6); chk("up_locked", locked_a, 1); chk("up_dir", dir_a, 0);
        smp(1, 7);
        smp(1, 0); chk("up_wrap_pulse", wrap_a, 1);
        smp(1, 1); chk("up_wrap_clear", wrap_a, 0); chk("up_wrap_count", wc_a, 1);
        chk("up_err_count", ec_a, 0);

        // down run with stall 2,1,1,0,7,6
        do_reset();
        smp(1, 2);
        smp(1, 1); chk("dn_locked", locked_a, 1); chk("dn_dir", dir_a, 1);
        smp(1, 1); chk("dn_hold_locked", locked_a, 1); chk("dn_hold_err", err_a, 0);
        smp(1, 0);
        smp(1, 7); chk("dn_wrap_pulse", wrap_a, 1);
        smp(1, 6); chk("dn_wrap_count", wc_a, 1); chk("dn_dir_end", dir_a, 1);

        // reversal 3,4,5,4,3
        do_reset();
        smp(1, 3); smp(1, 4); smp(1, 5);
        smp(1, 4); chk("rev_pulse", rev_a, 1); chk("rev_dir", dir_a, 1);
        smp(1, 3); chk("rev_single", rev_a, 0); chk("rev_locked", locked_a, 1);
        chk("rev_no_err", ec_a, 0);

        // illegal step while locked
        do_reset();
        smp(1, 1); smp(1, 2);
        smp(1, 5); chk("bad_pulse", err_a, 1); chk("bad_count", ec_a, 1);
        chk("bad_unlock", locked_a, 0);
        smp(1, 6); chk("relock", locked_a, 1); chk("relock_dir", dir_a, 0);
        chk("relock_no_err", err_a, 0); chk("relock_err_count", ec_a, 1);

        // bad step during acquisition, then reversal that also wraps
        do_reset();
        smp(1, 0);
        smp(1, 3); chk("acq_bad_pulse", err_a, 1); chk("acq_bad_locked", locked_a, 0);
        smp(1, 4); chk("acq_lock_after_bad", locked_a, 1); chk("acq_err_count", ec_a, 1);
        do_reset();
        smp(1, 1); smp(1, 0);
        smp(1, 7); chk("dn_wrap_locked", wrap_a, 1);
        smp(1, 0); chk("rev_wrap_rev", rev_a, 1); chk("rev_wrap_wrap", wrap_a, 1);
        chk("rev_wrap_dir", dir_a, 0); chk("rev_wrap_count", wc_a, 2);

        // saturation with 2-bit counters and in_valid gating
        do_reset();
        for (int i = 0; i <= 40; i++) smp(1, i % M);
        chk("sat_wide", wc_a, 5);
        chk("sat_narrow", wc_b, 3);
        smp(0, 0); chk("gate_wrap", wrap_a, 0); chk("gate_narrow", wc_b, 3);
        smp(0, 4); chk("gate_locked", locked_a, 1); chk("gate_err", err_a, 0);
        smp(1, 1); chk("gate_prev_held", err_a, 0); chk("gate_wrap_after", wrap_a, 0);

        // async reset mid-run
        do_reset();
        for (int i = 0; i <= 16; i++) smp(1, i % M);
        chk("mid_wrap_count", wc_a, 2);
        in_valid = 1'b0;
        #1 clr = 1'b0;
        #1;
        chk("async_locked", locked_a, 0);
        chk("async_wrap_count", wc_a, 0);
        chk("async_dir", dir_a, 0);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;
        smp(1, 6); chk("post_idle_locked", locked_a, 0); chk("post_idle_err", err_a, 0);
        smp(1, 7); chk("post_relock", locked_a, 1); chk("post_wrap_count", wc_a, 0);
        smp(0, 0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
